kbd_scan_ctrl: RTL and testbench

KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

---
 rtl/kbd_scan_if.sv | 24 ++
 rtl/kbd_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_kbd_scan_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_scan_if.sv
// Keyboard scanner bus: scan strobe, matrix row/column lines and the
// key handshake toward the consumer.
interface kbd_scan_if;
  logic       tick;
  logic [3:0] row_in;
  logic       key_ack;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       overrun;
  logic       busy;

  // Environment side: drives the strobe, the matrix rows and the acknowledge
  modport master (
    output tick, row_in, key_ack,
    input  col_out, key_code, key_valid, overrun, busy
  );

  // Scanner side
  modport slave (
    input  tick, row_in, key_ack,
    output col_out, key_code, key_valid, overrun, busy
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// 4x4 keyboard matrix scanner.
// Walks an active-low column, debounces the first low row it sees,
// hands the confirmed key to the consumer through a valid/ack register,
// then waits for the key to be released before scanning again.
// Key code is {row, col}, i.e. row*4+col.
module kbd_scan_ctrl #(
  parameter int DEB_TICKS = 4
) (
  input  logic       clk,
  input  logic       rst,
  kbd_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    SCAN         = 2'd0,
    DEBOUNCE     = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [3:0] DEB_LIM = 4'(DEB_TICKS);

  state_t     state_q;
  logic [1:0] col_q;
  logic [1:0] row_q;
  logic [3:0] cnt_q;
  logic [3:0] row_meta_q;
  logic [3:0] row_sync_q;
  logic [3:0] col_out_q;
  logic [3:0] key_code_q;
  logic       key_valid_q;
  logic       overrun_q;
  logic       busy_q;

  logic       cap_low;
  logic       cnt_hit;
  logic       confirm;
  logic [3:0] conf_code;

  // Index of the lowest-numbered row pulled low
  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    lowest_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) lowest_low = 2'(i);
    end
  endfunction

  // Active-low one-hot column drive
  function automatic logic [3:0] col_drive(input logic [1:0] col);
    col_drive = ~(4'b0001 << col);
  endfunction

  // Captured-row level, debounce-threshold detect and press confirmation strobe
  always_comb begin
    cap_low   = ~row_sync_q[row_q];
    cnt_hit   = ((cnt_q + 4'd1) == DEB_LIM);
    confirm   = bus.tick && (state_q == DEBOUNCE) && cap_low && cnt_hit;
    conf_code = {row_q, col_q};
  end

  // Two-flop synchronizer; reset value is the idle (released) level so that
  // leaving reset never looks like a keypress
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= bus.row_in;
      row_sync_q <= row_meta_q;
    end
  end

  // Scan/debounce FSM; every state change is gated by the scan strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= SCAN;
      col_q     <= 2'd0;
      row_q     <= 2'd0;
      cnt_q     <= 4'd0;
      col_out_q <= 4'b1110;
      busy_q    <= 1'b0;
    end else if (bus.tick) begin
      case (state_q)
        SCAN: begin
          if (&row_sync_q) begin
            col_q     <= col_q + 2'd1;
            col_out_q <= col_drive(col_q + 2'd1);
          end else begin
            row_q   <= lowest_low(row_sync_q);
            cnt_q   <= 4'd0;
            state_q <= DEBOUNCE;
            busy_q  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (cap_low) begin
            if (cnt_hit) begin
              cnt_q   <= 4'd0;
              state_q <= WAIT_RELEASE;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            // Bounce: drop the candidate and move on to the next column
            cnt_q     <= 4'd0;
            state_q   <= SCAN;
            busy_q    <= 1'b0;
            col_q     <= col_q + 2'd1;
            col_out_q <= col_drive(col_q + 2'd1);
          end
        end
        WAIT_RELEASE: begin
          if (!cap_low) begin
            if (cnt_hit) begin
              cnt_q     <= 4'd0;
              state_q   <= SCAN;
              busy_q    <= 1'b0;
              col_q     <= col_q + 2'd1;
              col_out_q <= col_drive(col_q + 2'd1);
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            cnt_q <= 4'd0;
          end
        end
        default: begin
          state_q <= SCAN;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

  // Key handshake: a confirmation wins over a plain ack, and an ack in the
  // same cycle frees the slot so the new key is taken instead of overrunning
  always_ff @(posedge clk) begin
    if (rst) begin
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else if (confirm) begin
      if (!key_valid_q || bus.key_ack) begin
        key_code_q  <= conf_code;
        key_valid_q <= 1'b1;
        overrun_q   <= 1'b0;
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (bus.key_ack && key_valid_q) begin
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end
  end

  assign bus.col_out   = col_out_q;
  assign bus.key_code  = key_code_q;
  assign bus.key_valid = key_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Testbench for kbd_scan_ctrl: directed scenarios followed by randomized
// row/ack traffic, all checked against a tick-level behavioural model.
module tb_kbd_scan_ctrl;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;

  kbd_scan_if bus ();

  kbd_scan_ctrl #(.DEB_TICKS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = scanning, 1 = debouncing a press,
  // 2 = waiting for release
  int   m_phase, m_col, m_row, m_run, m_code;
  bit   m_kv, m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_col = 0; m_row = 0; m_run = 0; m_code = 0;
    m_kv = 1'b0; m_ovr = 1'b0;
  endtask

  function automatic int first_low(input logic [3:0] rows);
    for (int r = 0; r < 4; r++) if (!rows[r]) return r;
    return -1;
  endfunction

  task automatic model_cycle(input bit t, input logic [3:0] rows, input bit ack);
    bit confirm = 1'b0;
    int new_code = 0;
    if (t) begin
      if (m_phase == 0) begin
        if (first_low(rows) < 0) m_col = (m_col + 1) % 4;
        else begin m_row = first_low(rows); m_run = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (!rows[m_row]) begin
          m_run++;
          if (m_run == DEB) begin
            confirm = 1'b1; new_code = m_row * 4 + m_col; m_run = 0; m_phase = 2;
          end
        end else begin
          m_run = 0; m_phase = 0; m_col = (m_col + 1) % 4;
        end
      end else begin
        if (rows[m_row]) begin
          m_run++;
          if (m_run == DEB) begin m_run = 0; m_phase = 0; m_col = (m_col + 1) % 4; end
        end else m_run = 0;
      end
    end
    if (confirm && (!m_kv || ack)) begin
      m_code = new_code; m_kv = 1'b1; m_ovr = 1'b0;
    end else if (confirm) m_ovr = 1'b1;
    else if (ack && m_kv) begin m_kv = 1'b0; m_ovr = 1'b0; end
  endtask

  function automatic logic [3:0] exp_col_out(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction

  task automatic compare_all();
    chk("col_out",   bus.col_out,   exp_col_out(m_col));
    chk("busy",      bus.busy,      (m_phase != 0));
    chk("key_valid", bus.key_valid, m_kv);
    chk("key_code",  bus.key_code,  m_code[3:0]);
    chk("overrun",   bus.overrun,   m_ovr);
  endtask

  // One clock: entered and left at a falling edge
  task automatic step(input bit t, input bit a);
    bus.tick = t; bus.key_ack = a;
    @(posedge clk);
    model_cycle(t, bus.row_in, a);
    @(negedge clk);
    bus.tick = 1'b0; bus.key_ack = 1'b0;
    compare_all();
  endtask

  task automatic reset_pulse(input bit t, input bit a);
    rst = 1'b1; bus.tick = t; bus.key_ack = a;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0; bus.tick = 1'b0; bus.key_ack = 1'b0;
    compare_all();
  endtask

  // Present a row pattern, let it settle through the synchronizer, then strobe
  task automatic tick_rows(input logic [3:0] rows, input bit ack_on_tick, input bit rnd_ack);
    int g;
    bus.row_in = rows;
    g = $urandom_range(3, 5);
    for (int i = 0; i < g; i++) step(1'b0, rnd_ack && ($urandom_range(0, 7) == 0));
    step(1'b1, ack_on_tick);
  endtask

  task automatic advance_to_col(input int c);
    for (int i = 0; i < 8 && m_col != c; i++) tick_rows(4'hF, 1'b0, 1'b0);
    chk("reach_col", bus.col_out, exp_col_out(c));
  endtask

  // Press key (r,c) until confirmed, then release until scanning resumes
  task automatic press(input int r, input int c, input bit ack_on_confirm);
    logic [3:0] rows;
    advance_to_col(c);
    rows = 4'hF;
    rows[r] = 1'b0;
    for (int i = 0; i < DEB + 1; i++) tick_rows(rows, ack_on_confirm && (i == DEB), 1'b0);
    for (int i = 0; i < DEB; i++) tick_rows(4'hF, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq [4];
    logic [3:0] pat;
    int hold;
    int c0;
    seq[0] = 4'b1110; seq[1] = 4'b1101; seq[2] = 4'b1011; seq[3] = 4'b0111;
    model_reset();
    rst = 1'b1; bus.tick = 1'b0; bus.key_ack = 1'b0; bus.row_in = 4'hF;
    repeat (3) @(negedge clk);
    reset_pulse(1'b0, 1'b0);
    chk("rst_col_out", bus.col_out, 4'b1110);
    chk("rst_busy",    bus.busy,    1'b0);
    chk("rst_valid",   bus.key_valid, 1'b0);
    chk("rst_code",    bus.key_code, 4'd0);
    chk("rst_ovr",     bus.overrun, 1'b0);

    // Free-running scan with no key
    for (int k = 1; k <= 8; k++) begin
      tick_rows(4'hF, 1'b0, 1'b0);
      chk("scan_seq", bus.col_out, seq[k % 4]);
    end

    // Row 2 on column 2 gives key 10 after the fifth tick
    advance_to_col(2);
    for (int i = 0; i < DEB + 1; i++) begin
      tick_rows(4'b1011, 1'b0, 1'b0);
      chk("deb_busy", bus.busy, 1'b1);
      chk("deb_valid", bus.key_valid, (i == DEB));
    end
    chk("key10_code", bus.key_code, 4'd10);
    for (int i = 0; i < DEB; i++) begin
      tick_rows(4'hF, 1'b0, 1'b0);
      chk("rel_busy", bus.busy, (i != DEB - 1));
    end
    chk("rel_col", bus.col_out, 4'b0111);
    step(1'b0, 1'b1);
    chk("ack_clears", bus.key_valid, 1'b0);

    // Short press aborts without a key
    advance_to_col(1);
    tick_rows(4'b1110, 1'b0, 1'b0);
    tick_rows(4'b1110, 1'b0, 1'b0);
    tick_rows(4'hF, 1'b0, 1'b0);
    chk("abort_valid", bus.key_valid, 1'b0);
    chk("abort_busy",  bus.busy, 1'b0);
    chk("abort_col",   bus.col_out, 4'b1011);

    // Overrun: key 5 pending, key 9 confirmed without ack
    press(1, 1, 1'b0);
    chk("k5_code", bus.key_code, 4'd5);
    press(2, 1, 1'b0);
    chk("ovr_code", bus.key_code, 4'd5);
    chk("ovr_flag", bus.overrun, 1'b1);
    step(1'b0, 1'b1);
    chk("ovr_ack_valid", bus.key_valid, 1'b0);
    chk("ovr_ack_flag",  bus.overrun, 1'b0);

    // Ack coincident with the confirming tick of key 9
    press(1, 1, 1'b0);
    press(2, 1, 1'b1);
    chk("sim_code",  bus.key_code, 4'd9);
    chk("sim_valid", bus.key_valid, 1'b1);
    chk("sim_ovr",   bus.overrun, 1'b0);
    step(1'b0, 1'b1);

    // Reset lands on a tick at debounce count 2
    advance_to_col(3);
    for (int i = 0; i < 3; i++) tick_rows(4'b1101, 1'b0, 1'b0);
    reset_pulse(1'b1, 1'b0);
    chk("rst_mid_col",  bus.col_out, 4'b1110);
    chk("rst_mid_busy", bus.busy, 1'b0);
    bus.row_in = 4'hF;
    for (int i = 0; i < 6; i++) tick_rows(4'hF, 1'b0, 1'b0);
    chk("rst_mid_nokey", bus.key_valid, 1'b0);

    // Randomized rows, bounces, acks and occasional resets
    c0 = 0;
    while (c0 < 300) begin
      case ($urandom_range(0, 3))
        0, 1:    pat = 4'hF;
        2:       begin pat = 4'hF; pat[$urandom_range(0, 3)] = 1'b0; end
        default: pat = 4'($urandom_range(0, 15));
      endcase
      hold = $urandom_range(1, 8);
      for (int i = 0; i < hold; i++) begin
        if ($urandom_range(0, 199) == 0) reset_pulse($urandom_range(0, 1) == 1, 1'b0);
        tick_rows(pat, $urandom_range(0, 5) == 0, 1'b1);
        c0++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
